// File: rtl/phy_link_ctrl_pkg.sv
// Shared types and defaults for the PHY link controller and the receive-side aligner.
package phy_link_ctrl_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned TS_REQ_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF  = 64;
    localparam int unsigned LOSS_REQ_DEF = 3;
    localparam int unsigned RETRAIN_W    = 8;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_TRAIN    = 2'd1,
        ST_LINK     = 2'd2
    } link_state_e;

    // Counter width able to hold 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phy_link_ctrl_sat_counter.sv
// Up-counter with synchronous clear that saturates at MAX and flags the terminal value.
module phy_link_ctrl_sat_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_term_c
);

    assign o_term_c = (o_cnt == W'(MAX));

    // Clear wins over increment; increment stops at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && !o_term_c) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/phy_link_ctrl.sv
// Link training / transmit sequencing: COM until the far end syncs, then data or IDLE words,
// falling back to training on receive loss and counting every retrain.
module phy_link_ctrl
    import phy_link_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter logic [7:0]  COM_SYM  = COM_SYM_DEF,
    parameter logic [7:0]  IDL_SYM  = IDL_SYM_DEF,
    parameter int unsigned TS_REQ   = TS_REQ_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
    parameter int unsigned LOSS_REQ = LOSS_REQ_DEF
) (
    input  logic                 clk_f,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 valid_in,
    output logic                 ready,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_valid,
    output logic                 active,
    input  logic [DATA_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic                 link_up,
    output logic                 err_timeout,
    output logic [RETRAIN_W-1:0] retrain_cnt
);

    localparam int unsigned NSYM    = DATA_W / 8;
    localparam int unsigned COM_W   = cnt_w(TS_REQ - 1);
    localparam int unsigned TIMER_W = cnt_w(TIMEOUT - 1);
    localparam int unsigned LOSS_W  = cnt_w(LOSS_REQ - 1);
    localparam int unsigned RT_MAX  = (1 << RETRAIN_W) - 1;

    localparam logic [DATA_W-1:0] COM_WORD = {NSYM{COM_SYM}};
    localparam logic [DATA_W-1:0] IDL_WORD = {NSYM{IDL_SYM}};

    link_state_e r_state;
    link_state_e w_state_nxt;

    logic [DATA_W-1:0]  w_tx_data_nxt;
    logic               w_tx_valid_nxt;
    logic               w_err_nxt;

    logic [COM_W-1:0]   w_com_cnt;
    logic [TIMER_W-1:0] w_timer;
    logic [LOSS_W-1:0]  w_loss_cnt;
    logic               w_com_term;
    logic               w_timer_term;
    logic               w_loss_term;
    logic               w_retrain_term;

    logic w_in_train;
    logic w_in_link;
    logic w_com_rx;
    logic w_com_done;
    logic w_timeout;
    logic w_loss;
    logic w_accept;
    logic w_cnt_unused;

    assign w_in_train = (r_state == ST_TRAIN);
    assign w_in_link  = (r_state == ST_LINK);
    assign w_com_rx   = rx_valid && (rx_data == COM_WORD);

    // Terminal flags sit one below the threshold, so they mark the edge that would reach it.
    assign w_com_done = w_in_train && w_com_rx && w_com_term;
    assign w_timeout  = w_in_train && w_timer_term && !w_com_done;
    assign w_loss     = w_in_link && !rx_valid && w_loss_term;

    // Never accept on a link-drop edge so the held word survives retraining.
    assign ready    = enable && w_in_link && !(!rx_valid && w_loss_term);
    assign w_accept = ready && valid_in;

    phy_link_ctrl_sat_counter #(.W(COM_W), .MAX(TS_REQ - 1)) u_com_cnt (
        .clk      (clk_f),
        .rst_n    (reset),
        .i_clr    (!enable || !w_in_train || !w_com_rx || w_com_done),
        .i_inc    (w_com_rx),
        .o_cnt    (w_com_cnt),
        .o_term_c (w_com_term)
    );

    phy_link_ctrl_sat_counter #(.W(TIMER_W), .MAX(TIMEOUT - 1)) u_timer (
        .clk      (clk_f),
        .rst_n    (reset),
        .i_clr    (!enable || !w_in_train || w_com_done || w_timeout),
        .i_inc    (1'b1),
        .o_cnt    (w_timer),
        .o_term_c (w_timer_term)
    );

    phy_link_ctrl_sat_counter #(.W(LOSS_W), .MAX(LOSS_REQ - 1)) u_loss_cnt (
        .clk      (clk_f),
        .rst_n    (reset),
        .i_clr    (!enable || !w_in_link || rx_valid || w_loss),
        .i_inc    (1'b1),
        .o_cnt    (w_loss_cnt),
        .o_term_c (w_loss_term)
    );

    // Only reset clears the retrain count; it is held through disable.
    phy_link_ctrl_sat_counter #(.W(RETRAIN_W), .MAX(RT_MAX)) u_retrain_cnt (
        .clk      (clk_f),
        .rst_n    (reset),
        .i_clr    (1'b0),
        .i_inc    (enable && (w_timeout || w_loss)),
        .o_cnt    (retrain_cnt),
        .o_term_c (w_retrain_term)
    );

    assign w_cnt_unused = ^{w_com_cnt, w_timer, w_loss_cnt, w_retrain_term};

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, then the output words derived from it.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_data_nxt  = '0;
        w_tx_valid_nxt = 1'b0;
        w_err_nxt      = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_DISABLED;
        end else begin
            case (r_state)
                ST_DISABLED: w_state_nxt = ST_TRAIN;
                ST_TRAIN: begin
                    if (w_com_done) begin
                        w_state_nxt = ST_LINK;
                    end else if (w_timeout) begin
                        w_err_nxt = 1'b1;
                    end
                end
                ST_LINK: begin
                    if (w_loss) begin
                        w_state_nxt = ST_TRAIN;
                    end
                end
                default: w_state_nxt = ST_DISABLED;
            endcase
        end

        case (w_state_nxt)
            ST_TRAIN: w_tx_data_nxt = COM_WORD;
            ST_LINK: begin
                if (w_accept) begin
                    w_tx_data_nxt  = data_in;
                    w_tx_valid_nxt = 1'b1;
                end else begin
                    w_tx_data_nxt = IDL_WORD;
                end
            end
            default: w_tx_data_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_f or negedge reset) begin
        if (!reset) begin
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            active      <= 1'b0;
            link_up     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_data     <= w_tx_data_nxt;
            tx_valid    <= w_tx_valid_nxt;
            active      <= (w_state_nxt == ST_LINK);
            link_up     <= (w_state_nxt == ST_LINK);
            err_timeout <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed and randomized checks of phy_link_ctrl against a cycle-level behavioural model.
module tb_phy_link_ctrl;

    localparam int TS_REQ   = 4;
    localparam int TIMEOUT  = 64;
    localparam int LOSS_REQ = 3;
    localparam logic [31:0] COMW = 32'hBCBCBCBC;
    localparam logic [31:0] IDLW = 32'h7C7C7C7C;
    localparam int M_DIS = 0, M_TRAIN = 1, M_LINK = 2;

    logic        clk_f = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        active;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        link_up;
    logic        err_timeout;
    logic [7:0]  retrain_cnt;

    phy_link_ctrl dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready       (ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .active      (active),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .link_up     (link_up),
        .err_timeout (err_timeout),
        .retrain_cnt (retrain_cnt)
    );

    always #5 clk_f = ~clk_f;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Behavioural model: mode plus plain integer counters.
    int          m_st, m_com, m_timer, m_loss, m_retrain;
    logic [31:0] e_tx;
    logic        e_txv, e_err;
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_DIS; m_com = 0; m_timer = 0; m_loss = 0; m_retrain = 0;
        e_tx = '0; e_txv = 1'b0; e_err = 1'b0;
    endtask

    function automatic bit model_ready();
        return enable && (m_st == M_LINK) && !(!rx_valid && (m_loss + 1 == LOSS_REQ));
    endfunction

    task automatic bump_retrain();
        if (m_retrain < 255) m_retrain++;
    endtask

    task automatic model_update(input bit rdy);
        bit acc, iscom;
        acc   = rdy && valid_in;
        iscom = rx_valid && (rx_data == COMW);
        e_err = 1'b0;
        if (!enable) begin
            m_st = M_DIS; m_com = 0; m_timer = 0; m_loss = 0;
        end else if (m_st == M_DIS) begin
            m_st = M_TRAIN;
        end else if (m_st == M_TRAIN) begin
            if (iscom && (m_com + 1 == TS_REQ)) begin
                m_st = M_LINK; m_com = 0; m_timer = 0;
            end else begin
                m_com = iscom ? m_com + 1 : 0;
                if (m_timer == TIMEOUT - 1) begin
                    e_err = 1'b1; m_timer = 0; bump_retrain();
                end else begin
                    m_timer++;
                end
            end
        end else begin
            if (rx_valid) m_loss = 0;
            else if (m_loss + 1 == LOSS_REQ) begin
                m_st = M_TRAIN; m_loss = 0; bump_retrain();
            end else m_loss++;
        end
        if (m_st == M_DIS)        begin e_tx = '0;   e_txv = 1'b0; end
        else if (m_st == M_TRAIN) begin e_tx = COMW; e_txv = 1'b0; end
        else if (acc)             begin e_tx = data_in; e_txv = 1'b1; end
        else                      begin e_tx = IDLW; e_txv = 1'b0; end
        last_acc = acc;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_tx_data"}, tx_data, e_tx);
        chk({pfx, "_tx_valid"}, tx_valid, e_txv);
        chk({pfx, "_active"}, active, m_st == M_LINK);
        chk({pfx, "_link_up"}, link_up, m_st == M_LINK);
        chk({pfx, "_err_timeout"}, err_timeout, e_err);
        chk({pfx, "_retrain_cnt"}, retrain_cnt, m_retrain);
    endtask

    // Inputs are set at posedge+1; ready is checked at +2, outputs at the next posedge+1.
    task automatic step(input string pfx);
        bit rdy;
        #1;
        rdy = model_ready();
        chk({pfx, "_ready"}, ready, rdy);
        model_update(rdy);
        @(posedge clk_f);
        #1;
        check_outputs(pfx);
    endtask

    task automatic set_rx(input bit v, input logic [31:0] d);
        rx_valid = v;
        rx_data  = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, pv, pc;
        reset = 1'b0; enable = 1'b0; data_in = '0; valid_in = 1'b0;
        set_rx(1'b0, '0);
        model_reset();
        last_acc = 1'b0;
        #3;
        check_outputs("reset");
        chk("reset_ready", ready, 1'b0);
        @(posedge clk_f); #1;
        reset = 1'b1;

        // Training completes on the edge after the 4th consecutive COM.
        enable = 1'b1;
        step("t1_enter");
        step("t1_idle");
        set_rx(1'b1, COMW);
        for (int i = 0; i < 4; i++) begin
            step("t1_com");
            chk("t1_link_edge", link_up, i == 3);
        end
        chk("t1_tx_idle", tx_data, IDLW);

        // A broken COM run restarts the count.
        enable = 1'b0; step("t2_dis");
        enable = 1'b1; set_rx(1'b0, '0); step("t2_enter");
        set_rx(1'b1, COMW);
        for (int i = 0; i < 3; i++) step("t2_com3");
        set_rx(1'b1, 32'h0); step("t2_break");
        chk("t2_no_early_link", link_up, 1'b0);
        set_rx(1'b1, COMW);
        for (int i = 0; i < 4; i++) begin
            step("t2_com4");
            chk("t2_link_edge", link_up, i == 3);
        end

        // Single data word, latency one, then IDLE.
        valid_in = 1'b1; data_in = 32'hDEADBEEF;
        step("t4_data");
        valid_in = 1'b0;
        chk("t4_word", tx_data, 32'hDEADBEEF);
        chk("t4_valid", tx_valid, 1'b1);
        step("t4_idle");
        chk("t4_idle_word", tx_data, IDLW);

        // Receive loss: word not taken on the drop edge, sent after re-link.
        valid_in = 1'b1; data_in = 32'hCAFEF00D; set_rx(1'b0, '0);
        step("t5_loss1"); step("t5_loss2");
        #1; chk("t5_ready_drop", ready, 1'b0);
        step("t5_loss3");
        chk("t5_train_tx", tx_data, COMW);
        chk("t5_retrain", retrain_cnt, 8'd1);
        set_rx(1'b1, COMW);
        for (int i = 0; i < 4; i++) step("t5_relink");
        step("t5_send");
        chk("t5_held_word", tx_data, 32'hCAFEF00D);
        valid_in = 1'b0;

        // Randomized traffic with varying receive quality.
        for (int c = 0; c < 10; c++) begin
            pv = $urandom_range(40, 98);
            pc = $urandom_range(50, 95);
            for (int i = 0; i < 300; i++) begin
                enable = ($urandom_range(0, 99) >= 2);
                set_rx($urandom_range(0, 99) < pv,
                       ($urandom_range(0, 99) < pc) ? COMW : $urandom);
                if (!valid_in || last_acc) begin
                    valid_in = ($urandom_range(0, 1) == 1);
                    data_in  = $urandom;
                end
                step("rnd");
            end
        end
        valid_in = 1'b0;

        // Training timeouts on an idle receiver.
        enable = 1'b0; step("t3_dis");
        enable = 1'b1; set_rx(1'b0, '0); step("t3_enter");
        base = m_retrain;
        for (int i = 1; i <= 130; i++) begin
            step("t3_idle");
            chk("t3_pulse", err_timeout, (i == 64) || (i == 128));
            chk("t3_inactive", active, 1'b0);
        end
        chk("t3_retrain", retrain_cnt, (base + 2 > 255) ? 255 : base + 2);

        // Retrain counter saturates.
        for (int i = 0; i < 256 * TIMEOUT; i++) step("sat");
        chk("sat_value", retrain_cnt, 8'd255);

        // Asynchronous reset in the middle of traffic.
        enable = 1'b0; step("t6_dis");
        enable = 1'b1; step("t6_enter");
        set_rx(1'b1, COMW);
        for (int i = 0; i < 4; i++) step("t6_com");
        valid_in = 1'b1; data_in = 32'h12345678;
        step("t6_traffic");
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("t6_async_rst");
        chk("t6_rst_ready", ready, 1'b0);
        #1;
        reset = 1'b1; valid_in = 1'b0;
        step("t6_enter2");
        for (int i = 0; i < 4; i++) step("t6_com2");
        chk("t6_relinked", link_up, 1'b1);
        enable = 1'b0;
        step("t6_disable");
        chk("t6_dis_tx", tx_data, 32'h0);
        chk("t6_dis_link", link_up, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
